// File: rtl/pipe_delay_pkg.sv
// Shared helpers for the pipe_delay_line elastic pipeline.
// Optional parity storage is selected with the PIPE_DELAY_LINE_PARITY_EN macro.
package pipe_delay_pkg;

    // Widest payload that even_par() accepts. Zero-extending a payload does not
    // change its parity.
    localparam int unsigned PAR_MAX_W = 1024;

    // Even-parity bit of a payload that has been zero-extended to PAR_MAX_W.
    function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

    // Width of an occupancy counter that holds 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_delay_line_if.sv
// Ready/valid bundle of the pipe_delay_line, covering the input side, the output side
// and the status outputs.
interface pipe_delay_line_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
    logic             out_perr;

    // The side that feeds the pipe and consumes its output.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, out_perr
    );

    // The pipe itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, out_perr
    );
endinterface

// File: rtl/pipe_delay_stage.sv
// A single pipe_delay_line register stage that holds valid, data and, when
// PIPE_DELAY_LINE_PARITY_EN is defined, parity.
// When load is high the stage takes its source values; otherwise it keeps its contents.
// Flush clears only the valid bit.
module pipe_delay_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
`ifdef PIPE_DELAY_LINE_PARITY_EN
    input  logic             src_par,
    output logic             par,
`endif
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
`ifdef PIPE_DELAY_LINE_PARITY_EN
        logic             par;
`endif
    } stage_t;

    stage_t           stage_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
`ifdef PIPE_DELAY_LINE_PARITY_EN
    logic             par_q;
`endif

    // Next contents: the source entry when loading, otherwise the held entry.
    always_comb begin
        stage_d.valid = valid_q;
        stage_d.data  = data_q;
`ifdef PIPE_DELAY_LINE_PARITY_EN
        stage_d.par   = par_q;
`endif
        if (load) begin
            stage_d.valid = src_valid;
            stage_d.data  = src_data;
`ifdef PIPE_DELAY_LINE_PARITY_EN
            stage_d.par   = src_par;
`endif
        end
    end

    // Stage register. Reset clears everything; flush drops only the entry's valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef PIPE_DELAY_LINE_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            valid_q <= flush ? 1'b0 : stage_d.valid;
            data_q  <= stage_d.data;
`ifdef PIPE_DELAY_LINE_PARITY_EN
            par_q   <= stage_d.par;
`endif
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
`ifdef PIPE_DELAY_LINE_PARITY_EN
    assign par   = par_q;
`endif

endmodule

// File: rtl/pipe_delay_line.sv
// pipe_delay_line is an elastic pipeline with DEPTH ready/valid stages.
// - Bubbles collapse, and a flush is synchronous.
// - The ready chain is combinational, so a full pipe still moves one entry per
//   cycle when out_ready is high.
// - Defining PIPE_DELAY_LINE_PARITY_EN adds per-entry even parity, which is checked
//   at the output.
module pipe_delay_line
    import pipe_delay_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_delay_line_if.slave   pipe
);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH:0]   ready;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];
`ifdef PIPE_DELAY_LINE_PARITY_EN
    logic [DEPTH-1:0] par;
    logic [DEPTH-1:0] src_par;
`endif
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Ready chain. A stage can load if it is empty or if its successor can load.
    always_comb begin
        ready        = '0;
        ready[DEPTH] = pipe.out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            ready[i] = ~valid[i] | ready[i+1];
        end
    end

    // Stage sources. Stage 0 takes the input port; every other stage takes its predecessor.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = pipe.in_valid & ~flush;
        src_data[0]  = pipe.in_data;
`ifdef PIPE_DELAY_LINE_PARITY_EN
        src_par      = '0;
        src_par[0]   = even_par(PAR_MAX_W'(pipe.in_data));
`endif
        for (int i = 1; i < int'(DEPTH); i++) begin
            src_valid[i] = valid[i-1];
            src_data[i]  = data[i-1];
`ifdef PIPE_DELAY_LINE_PARITY_EN
            src_par[i]   = par[i-1];
`endif
        end
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        pipe_delay_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .load      (ready[i]),
`ifdef PIPE_DELAY_LINE_PARITY_EN
            .src_par   (src_par[i]),
            .par       (par[i]),
`endif
            .src_valid (src_valid[i]),
            .src_data  (src_data[i]),
            .valid     (valid[i]),
            .data      (data[i])
        );
    end

    assign in_xfer  = pipe.in_valid & pipe.in_ready;
    assign out_xfer = pipe.out_valid & pipe.out_ready;

    // Occupancy: one up for each accepted entry and one down for each consumed entry.
    always_comb begin
        count_d = count_q + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end

    // Occupancy register. Flush empties the pipe; in_ready is low during a flush,
    // so no entry can arrive in that cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pipe.in_ready  = ~flush & ready[0];
    assign pipe.out_valid = valid[DEPTH-1];
    assign pipe.out_data  = data[DEPTH-1];
    assign pipe.count     = count_q;
`ifdef PIPE_DELAY_LINE_PARITY_EN
    assign pipe.out_perr  = valid[DEPTH-1] &
                            (even_par(PAR_MAX_W'(data[DEPTH-1])) != par[DEPTH-1]);
`else
    assign pipe.out_perr  = 1'b0;
`endif

endmodule
